ld3320_bus_responder: RTL and testbench
=======================================

// Module: ld3320_bus_responder
// PURPOSE
//  Responder (chip side) of the LD3320 8-bit parallel bus (A0/CSB/WRB/RDB/P). Models the LD3320
//  register interface inside the FPGA for loopback bring-up and simulation of the bus initiator.
//  Holds a 256x8 register file. Local logic reads and writes it through a side port, and every
//  bus write is reported as a one-cycle event.
// PARAMETERS
//  STATUS_ADDR   8'hB2  register that is read-only from the bus (chip status)
//  STATUS_RESET  8'h21  reset value of STATUS_ADDR; every other register resets to 8'h00
// PORTS
//  clk           in     1  system clock; the initiator runs on this same clock
//  rst_n         in     1  asynchronous reset, active low
//  A0            in     1  1 = address phase, 0 = data phase
//  CSB           in     1  chip select, active low
//  WRB           in     1  write strobe, active low
//  RDB           in     1  read strobe, active low
//  P             inout  8  bidirectional data bus
//  loc_wr        in     1  local write enable
//  loc_addr      in     8  local write/read address
//  loc_wdata     in     8  local write data
//  loc_rdata     out    8  regs[loc_addr], combinational
//  addr_ptr      out    8  currently latched register address
//  wr_evt        out    1  1-cycle pulse: bus data write accepted
//  wr_evt_addr   out    8  address of the accepted write, held until the next event
//  wr_evt_data   out    8  data of the accepted write, held until the next event
//  rd_evt        out    1  1-cycle pulse: bus data read started
//  bus_err       out    1  1-cycle pulse: CSB, WRB and RDB all low at the same time
// BEHAVIOUR
//  - Decode (combinational on the bus inputs):
//      wr_act = !CSB & !WRB &  RDB
//      rd_act = !CSB & !RDB &  WRB
//      err    = !CSB & !WRB & !RDB
//  - Strobe registers wr_q/rd_q hold the previous cycle's wr_act/rd_act.
//    An action fires only on the first cycle of assertion: wr_act & !wr_q, or rd_act & !rd_q.
//    A strobe held low N cycles therefore acts exactly once.
//  - Address write, at the posedge where a write fires with A0=1: addr_ptr <= P.
//  - Data write, at the posedge where a write fires with A0=0:
//      regs[addr_ptr] <= P
//      wr_evt = 1 next cycle; wr_evt_addr/wr_evt_data capture addr_ptr/P
//    If addr_ptr == STATUS_ADDR the register is left unchanged, but wr_evt still pulses.
//  - Data read:
//      P = regs[addr_ptr] combinationally whenever rd_act & !A0, so the initiator can sample
//      P in the same cycle RDB is low.
//      rd_evt pulses one cycle after the first cycle of rd_act & !A0.
//      A read with A0=1 returns addr_ptr on P and does not pulse rd_evt.
//  - P is high-Z at all other times, including during err and reset.
//    The block never drives P while WRB is low.
//  - err (all three strobes low): no register or addr_ptr update, P high-Z, bus_err pulses one
//    cycle later. If err persists, bus_err re-pulses only after err deasserts and reasserts.
//  - Local write, at the posedge with loc_wr=1: regs[loc_addr] <= loc_wdata. STATUS_ADDR is
//    writable from this port.
//  - Same-cycle bus data write and local write to the same address: the bus write wins,
//    except at STATUS_ADDR, where the local write wins. Different addresses both complete.
//  - Address and data transfers are each 1 cycle of strobe, matching the initiator's
//    one-cycle-per-phase timing. The initiator may omit address write-back; addr_ptr persists
//    across transactions.
//  - Reset, asynchronous, including mid-transaction:
//      addr_ptr = 0, regs = 0 except STATUS_ADDR = STATUS_RESET
//      wr_q = rd_q = 0; wr_evt, rd_evt, bus_err = 0; wr_evt_addr, wr_evt_data = 0; P high-Z
//    A strobe already low when rst_n rises counts as a fresh assertion on the first clock.
// TESTING
//  1. Address 8'h35 (A0=1, WRB low 1 cyc), then data 8'h80 (A0=0) -> regs[8'h35]=8'h80;
//     wr_evt 1 cyc with addr 8'h35, data 8'h80.
//  2. After test 1, RDB low 1 cyc with A0=0 -> P=8'h80 in that cycle, high-Z otherwise;
//     rd_evt 1 cyc.
//  3. Address 8'hB2, bus write 8'hFF -> status stays 8'h21 and reads back 8'h21; then
//     loc_wr 8'h35 to 8'hB2 -> bus read returns 8'h35.
//  4. WRB held low 3 cycles with A0=0, data 8'h11 then 8'h22 -> only 8'h11 is written;
//     wr_evt pulses once.
//  5. CSB=WRB=RDB=0 -> no write, P high-Z, bus_err 1 cyc. Same-cycle bus and local write to
//     8'h10 -> bus value stored.
//  6. rst_n low during a data-write strobe -> outputs at reset values, addr_ptr=0,
//     regs[8'hB2]=8'h21, P high-Z.

Source files
------------

// File: rtl/ld3320_bus_responder.sv
// Chip-side model of the LD3320 8-bit parallel bus: 256x8 register file, bus address/data
// phases on first-cycle strobe edges, a local side port, and one-cycle write/read/error events.
module ld3320_bus_responder #(
    parameter logic [7:0] STATUS_ADDR  = 8'hB2,
    parameter logic [7:0] STATUS_RESET = 8'h21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A0,
    input  logic       CSB,
    input  logic       WRB,
    input  logic       RDB,
    inout  wire  [7:0] P,
    input  logic       loc_wr,
    input  logic [7:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic [7:0] loc_rdata,
    output logic [7:0] addr_ptr,
    output logic       wr_evt,
    output logic [7:0] wr_evt_addr,
    output logic [7:0] wr_evt_data,
    output logic       rd_evt,
    output logic       bus_err
);

    logic [7:0] r_regs [256];
    logic [7:0] r_addr_ptr;
    logic       r_wr_q;
    logic       r_rd_q;
    logic       r_err_q;
    logic       r_wr_evt;
    logic [7:0] r_wr_evt_addr;
    logic [7:0] r_wr_evt_data;
    logic       r_rd_evt;
    logic       r_bus_err;

    logic       w_wr_act;
    logic       w_rd_act;
    logic       w_err;
    logic       w_wr_fire;
    logic       w_rd_fire;
    logic       w_addr_wr;
    logic       w_data_wr;
    logic       w_p_oe;
    logic [7:0] w_p_out;
    logic [7:0] w_p_in;

    assign w_wr_act  = !CSB && !WRB &&  RDB;
    assign w_rd_act  = !CSB && !RDB &&  WRB;
    assign w_err     = !CSB && !WRB && !RDB;

    // A held strobe acts once: only the cycle where the action is new counts.
    assign w_wr_fire = w_wr_act && !r_wr_q;
    assign w_rd_fire = w_rd_act && !r_rd_q;
    assign w_addr_wr = w_wr_fire &&  A0;
    assign w_data_wr = w_wr_fire && !A0;

    assign w_p_in    = P;

    // Reads are combinational so the initiator samples P in the same cycle RDB is low.
    // w_rd_act already requires WRB high, so P is never driven against a writing initiator.
    assign w_p_oe    = rst_n && w_rd_act;
    assign w_p_out   = A0 ? r_addr_ptr : r_regs[r_addr_ptr];
    assign P         = w_p_oe ? w_p_out : 8'bz;

    // NOTE: the register file is flop-based with an async reset because every entry has a
    // defined reset value; this rules out mapping it to a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                r_regs[i] <= (8'(i) == STATUS_ADDR) ? STATUS_RESET : 8'h00;
            end
        end else begin
            // The later assignment wins, giving the bus priority except at the status register.
            if (loc_wr) begin
                r_regs[loc_addr] <= loc_wdata;
            end
            if (w_data_wr && (r_addr_ptr != STATUS_ADDR)) begin
                r_regs[r_addr_ptr] <= w_p_in;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_ptr    <= 8'h00;
            r_wr_q        <= 1'b0;
            r_rd_q        <= 1'b0;
            r_err_q       <= 1'b0;
            r_wr_evt      <= 1'b0;
            r_wr_evt_addr <= 8'h00;
            r_wr_evt_data <= 8'h00;
            r_rd_evt      <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_wr_q    <= w_wr_act;
            r_rd_q    <= w_rd_act;
            r_err_q   <= w_err;
            r_wr_evt  <= w_data_wr;
            r_rd_evt  <= w_rd_fire && !A0;
            r_bus_err <= w_err && !r_err_q;
            if (w_addr_wr) begin
                r_addr_ptr <= w_p_in;
            end
            if (w_data_wr) begin
                r_wr_evt_addr <= r_addr_ptr;
                r_wr_evt_data <= w_p_in;
            end
        end
    end

    assign loc_rdata   = r_regs[loc_addr];
    assign addr_ptr    = r_addr_ptr;
    assign wr_evt      = r_wr_evt;
    assign wr_evt_addr = r_wr_evt_addr;
    assign wr_evt_data = r_wr_evt_data;
    assign rd_evt      = r_rd_evt;
    assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_ld3320_bus_responder.sv
// Directed bench for ld3320_bus_responder: bus initiator tasks, pulled-up P so a released
// bus reads 8'hFF, and hand-computed expectations for each phase.
module tb_ld3320_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       A0 = 1'b1;
    logic       CSB = 1'b1;
    logic       WRB = 1'b1;
    logic       RDB = 1'b1;
    logic       loc_wr = 1'b0;
    logic [7:0] loc_addr = 8'h00;
    logic [7:0] loc_wdata = 8'h00;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dat = 8'h00;
    tri1  [7:0] P;

    logic [7:0] loc_rdata;
    logic [7:0] addr_ptr;
    logic       wr_evt;
    logic [7:0] wr_evt_addr;
    logic [7:0] wr_evt_data;
    logic       rd_evt;
    logic       bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    assign P = tb_oe ? tb_dat : 8'bz;

    ld3320_bus_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A0          (A0),
        .CSB         (CSB),
        .WRB         (WRB),
        .RDB         (RDB),
        .P           (P),
        .loc_wr      (loc_wr),
        .loc_addr    (loc_addr),
        .loc_wdata   (loc_wdata),
        .loc_rdata   (loc_rdata),
        .addr_ptr    (addr_ptr),
        .wr_evt      (wr_evt),
        .wr_evt_addr (wr_evt_addr),
        .wr_evt_data (wr_evt_data),
        .rd_evt      (rd_evt),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        CSB   = 1'b1;
        WRB   = 1'b1;
        RDB   = 1'b1;
        tb_oe = 1'b0;
    endtask

    // One-cycle write strobe; returns just after the accepting edge with the bus released.
    task automatic bus_write(input logic a0, input logic [7:0] d);
        A0 = a0; CSB = 1'b0; WRB = 1'b0; RDB = 1'b1;
        tb_oe = 1'b1; tb_dat = d;
        tick();
        idle();
    endtask

    task automatic read_start(input logic a0);
        A0 = a0; CSB = 1'b0; WRB = 1'b1; RDB = 1'b0; tb_oe = 1'b0;
        #1;
    endtask

    task automatic peek(input logic [7:0] a);
        loc_addr = a;
        #1;
    endtask

    initial begin
        tick();
        tick();
        #2 rst_n = 1'b1;
        peek(8'hB2);
        check("rst_addr_ptr", addr_ptr, 8'h00);
        check("rst_wr_evt", {7'd0, wr_evt}, 8'h00);
        check("rst_rd_evt", {7'd0, rd_evt}, 8'h00);
        check("rst_bus_err", {7'd0, bus_err}, 8'h00);
        check("rst_status", loc_rdata, 8'h21);
        check("rst_p_hiz", P, 8'hFF);
        tick();

        // Address then data write.
        bus_write(1'b1, 8'h35);
        check("t1_addr_ptr", addr_ptr, 8'h35);
        check("t1_no_evt_addr", {7'd0, wr_evt}, 8'h00);
        tick();
        bus_write(1'b0, 8'h80);
        check("t1_wr_evt", {7'd0, wr_evt}, 8'h01);
        check("t1_evt_addr", wr_evt_addr, 8'h35);
        check("t1_evt_data", wr_evt_data, 8'h80);
        peek(8'h35);
        check("t1_reg35", loc_rdata, 8'h80);
        tick();
        check("t1_wr_evt_end", {7'd0, wr_evt}, 8'h00);
        check("t1_evt_addr_hold", wr_evt_addr, 8'h35);

        // Data read.
        read_start(1'b0);
        check("t2_p_read", P, 8'h80);
        tick();
        check("t2_rd_evt", {7'd0, rd_evt}, 8'h01);
        idle();
        #1;
        check("t2_p_release", P, 8'hFF);
        tick();
        check("t2_rd_evt_end", {7'd0, rd_evt}, 8'h00);

        // Status register: read-only from the bus, writable locally.
        bus_write(1'b1, 8'hB2);
        tick();
        bus_write(1'b0, 8'hFF);
        check("t3_wr_evt", {7'd0, wr_evt}, 8'h01);
        check("t3_evt_addr", wr_evt_addr, 8'hB2);
        check("t3_evt_data", wr_evt_data, 8'hFF);
        peek(8'hB2);
        check("t3_status_kept", loc_rdata, 8'h21);
        tick();
        read_start(1'b0);
        check("t3_p_status", P, 8'h21);
        tick();
        idle();
        tick();
        loc_wr = 1'b1; loc_addr = 8'hB2; loc_wdata = 8'h35;
        tick();
        loc_wr = 1'b0;
        read_start(1'b0);
        check("t3_p_status_loc", P, 8'h35);
        tick();
        idle();
        tick();
        read_start(1'b1);
        check("t3_p_addr_read", P, 8'hB2);
        tick();
        check("t3_no_rd_evt_a0", {7'd0, rd_evt}, 8'h00);
        idle();
        tick();

        // Held write strobe acts once.
        bus_write(1'b1, 8'h40);
        tick();
        A0 = 1'b0; CSB = 1'b0; WRB = 1'b0; RDB = 1'b1; tb_oe = 1'b1; tb_dat = 8'h11;
        tick();
        check("t4_wr_evt", {7'd0, wr_evt}, 8'h01);
        tb_dat = 8'h22;
        tick();
        check("t4_no_repulse1", {7'd0, wr_evt}, 8'h00);
        tick();
        check("t4_no_repulse2", {7'd0, wr_evt}, 8'h00);
        idle();
        tick();
        peek(8'h40);
        check("t4_reg40", loc_rdata, 8'h11);
        check("t4_evt_data", wr_evt_data, 8'h11);

        // All strobes low: error, no write, bus released.
        A0 = 1'b0; CSB = 1'b0; WRB = 1'b0; RDB = 1'b0; tb_oe = 1'b0;
        #1;
        check("t5_p_hiz_err", P, 8'hFF);
        tick();
        check("t5_bus_err", {7'd0, bus_err}, 8'h01);
        tick();
        check("t5_bus_err_once", {7'd0, bus_err}, 8'h00);
        tick();
        idle();
        tick();
        check("t5_no_wr_evt", {7'd0, wr_evt}, 8'h00);
        check("t5_reg40_kept", loc_rdata, 8'h11);
        check("t5_addr_kept", addr_ptr, 8'h40);
        CSB = 1'b0; WRB = 1'b0; RDB = 1'b0;
        tick();
        check("t5_bus_err_again", {7'd0, bus_err}, 8'h01);
        idle();
        tick();

        // Same-cycle bus and local writes.
        bus_write(1'b1, 8'h10);
        tick();
        loc_wr = 1'b1; loc_addr = 8'h10; loc_wdata = 8'h99;
        bus_write(1'b0, 8'h77);
        loc_wr = 1'b0;
        #1;
        check("t5_bus_wins", loc_rdata, 8'h77);
        tick();
        loc_wr = 1'b1; loc_addr = 8'h11; loc_wdata = 8'h66;
        bus_write(1'b0, 8'h55);
        loc_wr = 1'b0;
        peek(8'h10);
        check("t5_both_bus", loc_rdata, 8'h55);
        peek(8'h11);
        check("t5_both_loc", loc_rdata, 8'h66);
        tick();
        bus_write(1'b1, 8'hB2);
        tick();
        loc_wr = 1'b1; loc_addr = 8'hB2; loc_wdata = 8'h5C;
        bus_write(1'b0, 8'hAA);
        loc_wr = 1'b0;
        #1;
        check("t5_status_loc_wins", loc_rdata, 8'h5C);
        tick();

        // Reset in the middle of a data-write strobe.
        bus_write(1'b1, 8'h50);
        tick();
        A0 = 1'b0; CSB = 1'b0; WRB = 1'b0; RDB = 1'b1; tb_oe = 1'b1; tb_dat = 8'h44;
        #2 rst_n = 1'b0;
        #1;
        check("t6_addr_ptr", addr_ptr, 8'h00);
        check("t6_evt_addr", wr_evt_addr, 8'h00);
        check("t6_evt_data", wr_evt_data, 8'h00);
        check("t6_wr_evt", {7'd0, wr_evt}, 8'h00);
        peek(8'hB2);
        check("t6_status", loc_rdata, 8'h21);
        peek(8'h10);
        check("t6_reg10", loc_rdata, 8'h00);
        tb_oe = 1'b0;
        #1;
        check("t6_p_hiz", P, 8'hFF);
        tick();
        check("t6_held_wr_evt", {7'd0, wr_evt}, 8'h00);
        rst_n = 1'b1;
        tb_oe = 1'b1;
        tick();
        check("t6_fresh_wr_evt", {7'd0, wr_evt}, 8'h01);
        check("t6_fresh_addr", wr_evt_addr, 8'h00);
        check("t6_fresh_data", wr_evt_data, 8'h44);
        idle();
        peek(8'h00);
        check("t6_reg00", loc_rdata, 8'h44);
        peek(8'h50);
        check("t6_reg50", loc_rdata, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
